// File: rtl/mb_point_test_pattern_gen_pkg.sv
// Shared definitions for the mainband point-test pattern generator:
// control-word encodings, LFSR polynomial and per-lane seeds, burst sizes,
// valid-lane framing and the generator FSM states.
package mb_pattern_pkg;

  localparam int unsigned LFSR_W = 23;
  localparam int unsigned CNT_W  = 13;

  typedef enum logic [1:0] {
    CW_IDLE       = 2'b00,
    CW_CLEAR_LFSR = 2'b01,
    CW_LFSR       = 2'b10,
    CW_NOP        = 2'b11
  } cw_e;

  // Feedback taps of x^23+x^21+x^16+x^8+x^5+x^2+1 (x^23 term implicit).
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 23'h210125;

  // Element [n] is the seed of lanes n, n+8, ...
  localparam logic [7:0][LFSR_W-1:0] LANE_SEEDS = {
    23'h1BB807, 23'h0277CE, 23'h19CFC9, 23'h010F12,
    23'h18C0DB, 23'h1EC760, 23'h0607BB, 23'h1DBFBC
  };

  localparam int unsigned BURST_1K_UI = 1024;
  localparam int unsigned BURST_4K_UI = 4096;

  // Four UIs high then four low, LSB (earliest UI) first.
  localparam logic [7:0] VAL_FRAME = 8'h0F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_LFSR_RUN,
    ST_VAL_RUN,
    ST_DONE
  } pg_state_e;

  function automatic logic [LFSR_W-1:0] lane_seed(input int unsigned lane);
    return LANE_SEEDS[lane[2:0]];
  endfunction

endpackage

// File: rtl/mb_point_test_pattern_gen_if.sv
// Control/pattern bundle between the point-test TX controller (master) and
// the mainband pattern generator (slave).
//   i_mainband_pattern_generator_cw : 2-bit control word
//   i_val_pattern_en                : send valid-lane pattern only
//   i_burst_count                   : 0 = 1K UI, 1 = 4K UI
//   o_lane_data                     : NUM_LANES x UI_PER_CLK lane data
//   o_valid_lane                    : valid-lane framing bits
//   o_lane_data_valid               : beat carries a pattern
//   o_pattern_finished              : one-cycle end-of-burst pulse
interface mb_point_test_pattern_gen_if #(
  parameter int unsigned NUM_LANES  = 16,
  parameter int unsigned UI_PER_CLK = 32
);

  logic [1:0]                      i_mainband_pattern_generator_cw;
  logic                            i_val_pattern_en;
  logic                            i_burst_count;
  logic [NUM_LANES*UI_PER_CLK-1:0] o_lane_data;
  logic [UI_PER_CLK-1:0]           o_valid_lane;
  logic                            o_lane_data_valid;
  logic                            o_pattern_finished;

  modport master (
    output i_mainband_pattern_generator_cw,
    output i_val_pattern_en,
    output i_burst_count,
    input  o_lane_data,
    input  o_valid_lane,
    input  o_lane_data_valid,
    input  o_pattern_finished
  );

  modport slave (
    input  i_mainband_pattern_generator_cw,
    input  i_val_pattern_en,
    input  i_burst_count,
    output o_lane_data,
    output o_valid_lane,
    output o_lane_data_valid,
    output o_pattern_finished
  );

endinterface

// File: rtl/mb_point_test_pattern_gen_lfsr_lane.sv
// One lane of 23-bit Galois LFSR. Presents the next UI_PER_CLK output bits
// (bit 0 earliest) and steps UI_PER_CLK positions when advanced.
//   i_clk, i_rst_n : clock, async active-low reset (state returns to SEED)
//   i_load         : reload SEED (wins over i_advance)
//   i_advance      : step the state by one beat
//   o_word_c       : combinational word for the current state
module mb_lfsr_lane
  import mb_pattern_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED       = 23'h1DBFBC,
  parameter int unsigned       UI_PER_CLK = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_load,
  input  logic                  i_advance,
  output logic [UI_PER_CLK-1:0] o_word_c
);

  logic [LFSR_W-1:0] state_q;
  logic [LFSR_W-1:0] state_d;
  logic [LFSR_W-1:0] walk_c;

  // Unrolled UI_PER_CLK steps: emit MSB, then shift with feedback.
  always_comb begin
    walk_c   = state_q;
    o_word_c = '0;
    for (int unsigned i = 0; i < UI_PER_CLK; i++) begin
      o_word_c[i] = walk_c[LFSR_W-1];
      walk_c      = {walk_c[LFSR_W-2:0], 1'b0} ^ (walk_c[LFSR_W-1] ? LFSR_TAPS : '0);
    end
  end

  always_comb begin
    state_d = state_q;
    if (i_load) begin
      state_d = SEED;
    end else if (i_advance) begin
      state_d = walk_c;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/mb_point_test_pattern_gen.sv
// Mainband TX pattern generator for the RX-initiated data-to-clock point
// test. Sends a 1K/4K-UI burst of per-lane LFSR data (or valid-lane framing
// only), then pulses o_pattern_finished once.
//   i_clk, i_rst_n : clock, async active-low reset
//   pg             : control in / pattern out bundle (slave side)
module mb_point_test_pattern_gen
  import mb_pattern_pkg::*;
#(
  parameter int unsigned NUM_LANES  = 16,
  parameter int unsigned UI_PER_CLK = 32
) (
  input logic                        i_clk,
  input logic                        i_rst_n,
  mb_point_test_pattern_gen_if.slave pg
);

  localparam int unsigned DATA_W   = NUM_LANES * UI_PER_CLK;
  localparam int unsigned BEATS_1K = BURST_1K_UI / UI_PER_CLK;
  localparam int unsigned BEATS_4K = BURST_4K_UI / UI_PER_CLK;
  localparam logic [UI_PER_CLK-1:0] VAL_WORD = {(UI_PER_CLK / 8){VAL_FRAME}};

  pg_state_e             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  burst_q, burst_d;
  logic                  fin_sent_q, fin_sent_d;
  logic [DATA_W-1:0]     lane_data_q, lane_data_d;
  logic [UI_PER_CLK-1:0] valid_lane_q, valid_lane_d;
  logic                  data_valid_q, data_valid_d;
  logic                  finished_q, finished_d;

  logic                  load_c;
  logic                  advance_c;
  logic [DATA_W-1:0]     lane_words_c;
  logic                  cw_clear_c;
  logic                  cw_lfsr_c;
  logic                  val_en_c;
  logic                  last_beat_c;

  assign cw_clear_c  = (pg.i_mainband_pattern_generator_cw == CW_CLEAR_LFSR);
  assign cw_lfsr_c   = (pg.i_mainband_pattern_generator_cw == CW_LFSR);
  assign val_en_c    = pg.i_val_pattern_en;
  assign last_beat_c = (cnt_q == (burst_q ? CNT_W'(BEATS_4K - 1) : CNT_W'(BEATS_1K - 1)));

  // Per-lane LFSRs; lanes repeat the 8-seed table.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    mb_lfsr_lane #(
      .SEED       (lane_seed(l)),
      .UI_PER_CLK (UI_PER_CLK)
    ) u_lane (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_load    (load_c),
      .i_advance (advance_c),
      .o_word_c  (lane_words_c[l*UI_PER_CLK +: UI_PER_CLK])
    );
  end

  // Next state and next registered outputs; outputs default to zero.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    burst_d      = burst_q;
    fin_sent_d   = fin_sent_q;
    lane_data_d  = '0;
    valid_lane_d = '0;
    data_valid_d = 1'b0;
    finished_d   = 1'b0;
    load_c       = 1'b0;
    advance_c    = 1'b0;

    if (cw_clear_c) begin
      // Clear aborts anything, including a run in progress.
      state_d = ST_CLEAR;
      load_c  = 1'b1;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_CLEAR: begin
          if (cw_lfsr_c) begin
            state_d = ST_LFSR_RUN;
            cnt_d   = '0;
            burst_d = pg.i_burst_count;
          end else if (val_en_c) begin
            state_d = ST_VAL_RUN;
            cnt_d   = '0;
            burst_d = pg.i_burst_count;
          end
        end

        ST_LFSR_RUN: begin
          if (!cw_lfsr_c) begin
            // Abort: LFSR and counter are left as-is.
            state_d = ST_IDLE;
          end else begin
            lane_data_d  = lane_words_c;
            valid_lane_d = VAL_WORD;
            data_valid_d = 1'b1;
            advance_c    = 1'b1;
            cnt_d        = cnt_q + CNT_W'(1);
            if (last_beat_c) begin
              state_d    = ST_DONE;
              fin_sent_d = 1'b0;
            end
          end
        end

        ST_VAL_RUN: begin
          if (!val_en_c) begin
            state_d = ST_IDLE;
          end else begin
            valid_lane_d = VAL_WORD;
            data_valid_d = 1'b1;
            cnt_d        = cnt_q + CNT_W'(1);
            if (last_beat_c) begin
              state_d    = ST_DONE;
              fin_sent_d = 1'b0;
            end
          end
        end

        ST_DONE: begin
          // Pulse once, then hold until the controller drops its enables.
          finished_d = !fin_sent_q;
          fin_sent_d = 1'b1;
          if (!cw_lfsr_c && !val_en_c) begin
            state_d = ST_IDLE;
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      burst_q      <= 1'b0;
      fin_sent_q   <= 1'b0;
      lane_data_q  <= '0;
      valid_lane_q <= '0;
      data_valid_q <= 1'b0;
      finished_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      burst_q      <= burst_d;
      fin_sent_q   <= fin_sent_d;
      lane_data_q  <= lane_data_d;
      valid_lane_q <= valid_lane_d;
      data_valid_q <= data_valid_d;
      finished_q   <= finished_d;
    end
  end

  assign pg.o_lane_data        = lane_data_q;
  assign pg.o_valid_lane       = valid_lane_q;
  assign pg.o_lane_data_valid  = data_valid_q;
  assign pg.o_pattern_finished = finished_q;

endmodule
